// File: rtl/multicycle_datapath_if.sv
// Control/status and unified-memory bundle between the multicycle MIPS datapath
// and its controller/memory. The datapath uses the slave modport.
interface multicycle_datapath_if;
   logic        IorD;
   logic        ALUSrcA;
   logic [1:0]  ALUSrcB;
   logic [1:0]  PCSrc;
   logic        IRWrite;
   logic        PCWrite;
   logic        MemWrite;
   logic        RegDst;
   logic        MemtoReg;
   logic        RegWrite;
   logic        Branch;
   logic [1:0]  ALUOp;
   logic [31:0] RD;
   logic [5:0]  OP;
   logic [5:0]  Funct;
   logic [31:0] ADR;
   logic [31:0] WD;
   logic        WE;
   logic [31:0] outputPC;
   logic        PCEn;
   logic        Zero;

   modport master (
      output IorD, ALUSrcA, ALUSrcB, PCSrc, IRWrite, PCWrite, MemWrite,
             RegDst, MemtoReg, RegWrite, Branch, ALUOp, RD,
      input  OP, Funct, ADR, WD, WE, outputPC, PCEn, Zero
   );

   modport slave (
      input  IorD, ALUSrcA, ALUSrcB, PCSrc, IRWrite, PCWrite, MemWrite,
             RegDst, MemtoReg, RegWrite, Branch, ALUOp, RD,
      output OP, Funct, ADR, WD, WE, outputPC, PCEn, Zero
   );
endinterface

// File: rtl/multicycle_datapath.sv
// Multicycle 32-bit MIPS datapath: PC, IR, MDR, register file, ALU and holding regs.
// Define DATAPATH_JUMP_EN to let PCSrc=10 select the J-type jump target.
module multicycle_datapath (
   input  logic                  clk,
   input  logic                  rst,
   multicycle_datapath_if.slave  bus
);
   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_SLT = 3'd4;

   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic [31:0] data_q, data_d;
   logic [31:0] a_q, a_d;
   logic [31:0] b_q, b_d;
   logic [31:0] alu_out_q, alu_out_d;
   logic [31:0] rf_q [32];
   logic [31:0] rf_d [32];

   logic [4:0]         rs, rt, a3;
   logic [31:0]        sign_imm, src_a, src_b, alu_result, pc_next, wd3;
   logic signed [31:0] src_a_s, src_b_s;
   logic [2:0]         alu_ctl;
   logic               zero, pc_en;

   assign rs       = instr_q[25:21];
   assign rt       = instr_q[20:16];
   assign a3       = bus.RegDst ? instr_q[15:11] : instr_q[20:16];
   assign wd3      = bus.MemtoReg ? data_q : alu_out_q;
   assign sign_imm = {{16{instr_q[15]}}, instr_q[15:0]};

   always_comb begin
      alu_ctl = ALU_ADD;
      case (bus.ALUOp)
         2'b01:   alu_ctl = ALU_SUB;
         2'b11:   alu_ctl = ALU_OR;
         2'b10: begin
            case (instr_q[5:0])
               6'b100010: alu_ctl = ALU_SUB;
               6'b100100: alu_ctl = ALU_AND;
               6'b100101: alu_ctl = ALU_OR;
               6'b101010: alu_ctl = ALU_SLT;
               default:   alu_ctl = ALU_ADD;
            endcase
         end
         default: alu_ctl = ALU_ADD;
      endcase
   end

   always_comb begin
      src_a = bus.ALUSrcA ? a_q : pc_q;
      case (bus.ALUSrcB)
         2'b00:   src_b = b_q;
         2'b01:   src_b = 32'd4;
         2'b10:   src_b = sign_imm;
         default: src_b = {sign_imm[29:0], 2'b00};
      endcase
   end

   assign src_a_s = src_a;
   assign src_b_s = src_b;

   always_comb begin
      case (alu_ctl)
         ALU_SUB: alu_result = src_a - src_b;
         ALU_AND: alu_result = src_a & src_b;
         ALU_OR:  alu_result = src_a | src_b;
         ALU_SLT: alu_result = {31'd0, (src_a_s < src_b_s)};
         default: alu_result = src_a + src_b;
      endcase
   end

   assign zero  = (alu_result == 32'd0);
   assign pc_en = bus.PCWrite | (bus.Branch & zero);

   // Without the jump option, PCSrc=10 falls into the ALUResult default.
   always_comb begin
      pc_next = alu_result;
      case (bus.PCSrc)
         2'b01:   pc_next = alu_out_q;
`ifdef DATAPATH_JUMP_EN
         2'b10:   pc_next = {pc_q[31:28], instr_q[25:0], 2'b00};
`endif
         default: pc_next = alu_result;
      endcase
   end

   always_comb begin
      pc_d      = pc_en ? pc_next : pc_q;
      instr_d   = bus.IRWrite ? bus.RD : instr_q;
      data_d    = bus.RD;
      a_d       = (rs == 5'd0) ? 32'd0 : rf_q[rs];
      b_d       = (rt == 5'd0) ? 32'd0 : rf_q[rt];
      alu_out_d = alu_result;
      rf_d      = rf_q;
      if (bus.RegWrite && (a3 != 5'd0)) begin
         rf_d[a3] = wd3;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         pc_q      <= '0;
         instr_q   <= '0;
         data_q    <= '0;
         a_q       <= '0;
         b_q       <= '0;
         alu_out_q <= '0;
         rf_q      <= '{default: '0};
      end else begin
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         data_q    <= data_d;
         a_q       <= a_d;
         b_q       <= b_d;
         alu_out_q <= alu_out_d;
         rf_q      <= rf_d;
      end
   end

   assign bus.OP       = instr_q[31:26];
   assign bus.Funct    = instr_q[5:0];
   assign bus.ADR      = bus.IorD ? alu_out_q : pc_q;
   assign bus.WD       = b_q;
   assign bus.WE       = bus.MemWrite;
   assign bus.outputPC = pc_q;
   assign bus.PCEn     = pc_en;
   assign bus.Zero     = zero;
endmodule

// File: tb/tb_multicycle_datapath.sv
// Self-checking bench for multicycle_datapath: directed instruction sequences plus
// randomized control/data checked against an instruction-level reference model.
module tb_multicycle_datapath;
   logic clk = 1'b0;
   logic rst;
   int   n_checks = 0;
   int   n_fail   = 0;

   multicycle_datapath_if bus ();
   multicycle_datapath dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // reference machine state
   logic [31:0] m_pc, m_instr, m_data, m_a, m_b, m_aluout;
   logic [31:0] m_rf [32];

   function automatic logic [31:0] m_alu();
      logic [31:0] sa, sb, imm;
      int          simm;
      simm = $signed(m_instr[15:0]);
      imm  = simm;
      sa   = bus.ALUSrcA ? m_a : m_pc;
      case (bus.ALUSrcB)
         2'd0:    sb = m_b;
         2'd1:    sb = 32'd4;
         2'd2:    sb = imm;
         default: sb = imm * 4;
      endcase
      case (bus.ALUOp)
         2'd0: return sa + sb;
         2'd1: return sa - sb;
         2'd3: return sa | sb;
         default: begin
            case (m_instr[5:0])
               6'h22:   return sa - sb;
               6'h24:   return sa & sb;
               6'h25:   return sa | sb;
               6'h2a:   return ($signed(sa) < $signed(sb)) ? 32'd1 : 32'd0;
               default: return sa + sb;
            endcase
         end
      endcase
   endfunction

   function automatic logic [110:0] m_outs();
      logic [31:0] res;
      logic        z;
      res = m_alu();
      z   = (res == 32'd0);
      return {m_instr[31:26], m_instr[5:0], bus.IorD ? m_aluout : m_pc, m_b,
              bus.MemWrite, m_pc, bus.PCWrite | (bus.Branch & z), z};
   endfunction

   task automatic clear_ctrl();
      bus.IorD = 0; bus.ALUSrcA = 0; bus.ALUSrcB = 2'd0; bus.PCSrc = 2'd0;
      bus.IRWrite = 0; bus.PCWrite = 0; bus.MemWrite = 0; bus.RegDst = 0;
      bus.MemtoReg = 0; bus.RegWrite = 0; bus.Branch = 0; bus.ALUOp = 2'd0;
      bus.RD = 32'd0;
   endtask

   // Advance model and DUT by one rising edge using the currently driven inputs.
   task automatic step();
      logic [31:0] res, npc, wd3, na, nb;
      logic [4:0]  a3;
      res = m_alu();
      if (!rst) begin
         m_pc = 0; m_instr = 0; m_data = 0; m_a = 0; m_b = 0; m_aluout = 0;
         for (int i = 0; i < 32; i++) m_rf[i] = 32'd0;
      end else begin
         case (bus.PCSrc)
            2'd1:    npc = m_aluout;
`ifdef DATAPATH_JUMP_EN
            2'd2:    npc = {m_pc[31:28], m_instr[25:0], 2'b00};
`endif
            default: npc = res;
         endcase
         na  = m_rf[m_instr[25:21]];
         nb  = m_rf[m_instr[20:16]];
         a3  = bus.RegDst ? m_instr[15:11] : m_instr[20:16];
         wd3 = bus.MemtoReg ? m_data : m_aluout;
         if (bus.PCWrite || (bus.Branch && res == 32'd0)) m_pc = npc;
         if (bus.IRWrite) m_instr = bus.RD;
         m_data   = bus.RD;
         m_a      = na;
         m_b      = nb;
         m_aluout = res;
         if (bus.RegWrite && a3 != 5'd0) m_rf[a3] = wd3;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clear_ctrl();
      step();
      rst = 1'b1;
   endtask

   task automatic fetch(input logic [31:0] instr);
      clear_ctrl();
      bus.IRWrite = 1; bus.PCWrite = 1; bus.ALUSrcB = 2'd1; bus.RD = instr;
      step();
   endtask

   task automatic run_addi(input logic [31:0] instr);
      fetch(instr);
      clear_ctrl(); bus.ALUSrcA = 1; bus.ALUSrcB = 2'd2;
      step();
      clear_ctrl(); bus.RegWrite = 1;
      step();
   endtask

   // Leaves the sw in its memory-access cycle with IorD/MemWrite driven, before the edge.
   task automatic sw_to_mem(input logic [31:0] instr);
      fetch(instr);
      clear_ctrl();
      step();
      clear_ctrl(); bus.ALUSrcA = 1; bus.ALUSrcB = 2'd2;
      step();
      clear_ctrl(); bus.IorD = 1; bus.MemWrite = 1;
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b0;
      clear_ctrl();
      bus.PCWrite = 1; bus.IRWrite = 1; bus.RegWrite = 1; bus.RD = 32'hFFFF_FFFF;
      step();
      bus.MemWrite = 1; bus.IorD = 0;
      #1;
      n_checks++; if (bus.outputPC !== 32'd0) begin n_fail++; $display("FAIL reset_pc: got %h want 0", bus.outputPC); end
      n_checks++; if (bus.ADR !== 32'd0) begin n_fail++; $display("FAIL reset_adr: got %h want 0", bus.ADR); end
      n_checks++; if (bus.OP !== 6'd0) begin n_fail++; $display("FAIL reset_op: got %h want 0", bus.OP); end
      n_checks++; if (bus.Funct !== 6'd0) begin n_fail++; $display("FAIL reset_funct: got %h want 0", bus.Funct); end
      n_checks++; if (bus.WD !== 32'd0) begin n_fail++; $display("FAIL reset_wd: got %h want 0", bus.WD); end
      n_checks++; if (bus.WE !== 1'b1) begin n_fail++; $display("FAIL reset_we: got %b want 1", bus.WE); end
      rst = 1'b1;
      clear_ctrl();
   endtask

   task automatic test_fetch_addi_sw();
      do_reset();
      fetch(32'h2002_0005);
      n_checks++; if (bus.OP !== 6'b001000) begin n_fail++; $display("FAIL fetch_op: got %b want 001000", bus.OP); end
      n_checks++; if (bus.outputPC !== 32'd4) begin n_fail++; $display("FAIL fetch_pc: got %h want 4", bus.outputPC); end
      n_checks++; if (bus.ADR !== 32'd4) begin n_fail++; $display("FAIL fetch_adr: got %h want 4", bus.ADR); end
      clear_ctrl(); bus.ALUSrcA = 1; bus.ALUSrcB = 2'd2;
      step();
      clear_ctrl(); bus.RegWrite = 1;
      step();
      sw_to_mem(32'hAC02_0000);
      n_checks++; if (bus.WD !== 32'd5) begin n_fail++; $display("FAIL sw_wd: got %h want 5", bus.WD); end
      n_checks++; if (bus.ADR !== 32'd0) begin n_fail++; $display("FAIL sw_adr: got %h want 0", bus.ADR); end
      n_checks++; if (bus.WE !== 1'b1) begin n_fail++; $display("FAIL sw_we: got %b want 1", bus.WE); end
      step();
   endtask

   task automatic test_rtype();
      run_addi(32'h2003_0003);
      fetch(32'h0043_2022);
      clear_ctrl();
      step();
      clear_ctrl(); bus.ALUSrcA = 1; bus.ALUOp = 2'd2;
      step();
      bus.IorD = 1;
      #1;
      n_checks++; if (bus.ADR !== 32'd2) begin n_fail++; $display("FAIL sub_aluout: got %h want 2", bus.ADR); end
      clear_ctrl(); bus.RegDst = 1; bus.RegWrite = 1;
      step();
      sw_to_mem(32'hAC04_0000);
      n_checks++; if (bus.WD !== 32'd2) begin n_fail++; $display("FAIL sub_wb_wd: got %h want 2", bus.WD); end
      step();
   endtask

   task automatic test_branch();
      logic [31:0] tgt, hold;
      // beq $2,$2,+3 : taken
      fetch(32'h1042_0003);
      tgt = m_pc + 32'd12;
      clear_ctrl(); bus.ALUSrcB = 2'd3;
      step();
      clear_ctrl(); bus.ALUSrcA = 1; bus.ALUOp = 2'd1; bus.Branch = 1; bus.PCSrc = 2'd1;
      #1;
      n_checks++; if (bus.Zero !== 1'b1) begin n_fail++; $display("FAIL beq_eq_zero: got %b want 1", bus.Zero); end
      n_checks++; if (bus.PCEn !== 1'b1) begin n_fail++; $display("FAIL beq_eq_pcen: got %b want 1", bus.PCEn); end
      step();
      n_checks++; if (bus.outputPC !== tgt) begin n_fail++; $display("FAIL beq_eq_pc: got %h want %h", bus.outputPC, tgt); end
      // beq $2,$3,+3 : not taken
      fetch(32'h1043_0003);
      hold = m_pc;
      clear_ctrl(); bus.ALUSrcB = 2'd3;
      step();
      clear_ctrl(); bus.ALUSrcA = 1; bus.ALUOp = 2'd1; bus.Branch = 1; bus.PCSrc = 2'd1;
      #1;
      n_checks++; if (bus.Zero !== 1'b0) begin n_fail++; $display("FAIL beq_ne_zero: got %b want 0", bus.Zero); end
      n_checks++; if (bus.PCEn !== 1'b0) begin n_fail++; $display("FAIL beq_ne_pcen: got %b want 0", bus.PCEn); end
      step();
      n_checks++; if (bus.outputPC !== hold) begin n_fail++; $display("FAIL beq_ne_pc: got %h want %h", bus.outputPC, hold); end
   endtask

   task automatic test_jump();
      do_reset();
`ifdef DATAPATH_JUMP_EN
      fetch(32'h0000_0000);
      fetch(32'h0800_0010);
      n_checks++; if (bus.outputPC !== 32'h8) begin n_fail++; $display("FAIL jump_pre_pc: got %h want 8", bus.outputPC); end
      clear_ctrl(); bus.PCWrite = 1; bus.PCSrc = 2'd2;
      step();
      n_checks++; if (bus.outputPC !== 32'h40) begin n_fail++; $display("FAIL jump_pc: got %h want 40", bus.outputPC); end
`else
      fetch(32'h0800_0010);
      clear_ctrl(); bus.PCWrite = 1; bus.PCSrc = 2'd2; bus.ALUSrcB = 2'd1;
      step();
      n_checks++; if (bus.outputPC !== 32'h8) begin n_fail++; $display("FAIL pcsrc10_pc: got %h want 8", bus.outputPC); end
`endif
   endtask

   task automatic test_random();
      logic [110:0] exp_v, got_v;
      do_reset();
      for (int i = 0; i < 400; i++) begin
         rst          = ($urandom_range(0, 31) != 0);
         bus.IorD     = 1'($urandom);
         bus.ALUSrcA  = 1'($urandom);
         bus.ALUSrcB  = 2'($urandom);
         bus.PCSrc    = 2'($urandom);
         bus.IRWrite  = 1'($urandom);
         bus.PCWrite  = 1'($urandom);
         bus.MemWrite = 1'($urandom);
         bus.RegDst   = 1'($urandom);
         bus.MemtoReg = 1'($urandom);
         bus.RegWrite = 1'($urandom);
         bus.Branch   = 1'($urandom);
         bus.ALUOp    = 2'($urandom);
         bus.RD       = $urandom;
         #1;
         exp_v = m_outs();
         got_v = {bus.OP, bus.Funct, bus.ADR, bus.WD, bus.WE, bus.outputPC, bus.PCEn, bus.Zero};
         n_checks++;
         if (got_v !== exp_v) begin
            n_fail++;
            $display("FAIL random_outs[%0d]: got %h want %h", i, got_v, exp_v);
         end
         step();
      end
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0;
      clear_ctrl();
      test_reset();
      test_fetch_addi_sw();
      test_rtype();
      test_branch();
      test_jump();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
